// File: rtl/input_port_bank.sv
// Read side of the CPU I/O port space: synchronises 16 input ports, flags changes and serves
// registered reads. Optional change interrupt enabled by defining PORT_IN_IRQ_EN.
module input_port_bank #(
  parameter logic [7:0]  BASE_ADDR   = 8'h80,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  port_in_00,
  input  logic [7:0]  port_in_01,
  input  logic [7:0]  port_in_02,
  input  logic [7:0]  port_in_03,
  input  logic [7:0]  port_in_04,
  input  logic [7:0]  port_in_05,
  input  logic [7:0]  port_in_06,
  input  logic [7:0]  port_in_07,
  input  logic [7:0]  port_in_08,
  input  logic [7:0]  port_in_09,
  input  logic [7:0]  port_in_10,
  input  logic [7:0]  port_in_11,
  input  logic [7:0]  port_in_12,
  input  logic [7:0]  port_in_13,
  input  logic [7:0]  port_in_14,
  input  logic [7:0]  port_in_15,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_hit,
  input  logic        irq_mask_wr,
  input  logic [15:0] irq_mask_din,
  output logic        irq
);

  localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);
  localparam logic [CntW-1:0] WarmInit = CntW'(SYNC_STAGES + 1);

  if (int'(BASE_ADDR) > 238) begin : g_bad_base
    $error("BASE_ADDR + 17 exceeds 8'hFF");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [7:0] pins [16];
  assign pins = '{port_in_00, port_in_01, port_in_02, port_in_03, port_in_04, port_in_05,
                  port_in_06, port_in_07, port_in_08, port_in_09, port_in_10, port_in_11,
                  port_in_12, port_in_13, port_in_14, port_in_15};

  // Stage 0 takes the raw pin; stage SYNC_STAGES-1 is the synchronised value.
  logic [SYNC_STAGES-1:0][7:0] chain_q [16];
  logic [7:0]                  sync    [16];
  logic [7:0]                  prev_q  [16];
  logic [CntW-1:0]             warm_q;
  logic [15:0]                 flag_q, flag_d, chg, clr;

  logic [7:0] rd_off;
  logic       port_sel, flo_sel, fhi_sel;
  logic [7:0] rd_data_d;

  always_comb begin
    chg = '0;
    for (int k = 0; k < 16; k++) begin
      sync[k] = chain_q[k][SYNC_STAGES-1];
      chg[k]  = (sync[k] != prev_q[k]) && (warm_q == '0);
    end
  end

  always_comb begin
    rd_off    = rd_addr - BASE_ADDR;
    port_sel  = rd_off < 8'd16;
    flo_sel   = rd_off == 8'd16;
    fhi_sel   = rd_off == 8'd17;
    clr       = '0;
    rd_data_d = '0;
    if (port_sel) begin
      rd_data_d = sync[rd_off[3:0]];
      if (rd_en) clr[rd_off[3:0]] = 1'b1;
    end else if (flo_sel) begin
      rd_data_d = flag_q[7:0];
    end else if (fhi_sel) begin
      rd_data_d = flag_q[15:8];
    end
    // A change landing on the clearing read keeps the flag set.
    flag_d = (flag_q & ~clr) | chg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        chain_q[k] <= '0;
        prev_q[k]  <= '0;
      end
      warm_q   <= WarmInit;
      flag_q   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        chain_q[k] <= {chain_q[k][SYNC_STAGES-2:0], pins[k]};
        prev_q[k]  <= sync[k];
      end
      if (warm_q != '0) warm_q <= warm_q - 1'b1;
      flag_q   <= flag_d;
      rd_valid <= rd_en;
      rd_hit   <= rd_en && (port_sel || flo_sel || fhi_sel);
      if (rd_en) rd_data <= rd_data_d;
    end
  end

`ifdef PORT_IN_IRQ_EN
  logic [15:0] mask_q;
  logic        irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (irq_mask_wr) mask_q <= irq_mask_din;
      irq_q <= |(flag_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_mask_wr, irq_mask_din};
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_bank.sv
// Directed bench for input_port_bank (BASE_ADDR=8'h80, SYNC_STAGES=2); covers the interrupt
// path as well when PORT_IN_IRQ_EN is defined.
module tb_input_port_bank;

`ifdef PORT_IN_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pin [16];
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_hit;
  logic        irq_mask_wr;
  logic [15:0] irq_mask_din;
  logic        irq;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  input_port_bank #(
    .BASE_ADDR   (8'h80),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_in_00   (pin[0]),
    .port_in_01   (pin[1]),
    .port_in_02   (pin[2]),
    .port_in_03   (pin[3]),
    .port_in_04   (pin[4]),
    .port_in_05   (pin[5]),
    .port_in_06   (pin[6]),
    .port_in_07   (pin[7]),
    .port_in_08   (pin[8]),
    .port_in_09   (pin[9]),
    .port_in_10   (pin[10]),
    .port_in_11   (pin[11]),
    .port_in_12   (pin[12]),
    .port_in_13   (pin[13]),
    .port_in_14   (pin[14]),
    .port_in_15   (pin[15]),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_hit       (rd_hit),
    .irq_mask_wr  (irq_mask_wr),
    .irq_mask_din (irq_mask_din),
    .irq          (irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic hit, input logic [7:0] data);
    check({tag, ".valid"}, {15'd0, rd_valid}, 16'd1);
    check({tag, ".hit"},   {15'd0, rd_hit},   {15'd0, hit});
    check({tag, ".data"},  {8'd0, rd_data},   {8'd0, data});
  endtask

  initial begin
    for (int k = 0; k < 16; k++) pin[k] = 8'h00;
    pin[3]       = 8'hA5;
    rst          = 1'b1;
    rd_en        = 1'b0;
    rd_addr      = 8'h00;
    irq_mask_wr  = 1'b0;
    irq_mask_din = 16'h0000;

    // T1: reset, then warm-up must not flag the A5 already on pin 3
    tick(2);
    check("t1.rd_data",  {8'd0, rd_data},   16'h0000);
    check("t1.rd_valid", {15'd0, rd_valid}, 16'h0000);
    check("t1.rd_hit",   {15'd0, rd_hit},   16'h0000);
    check("t1.irq",      {15'd0, irq},      16'h0000);
    rst = 1'b0;
    tick(4);
    rd_en = 1'b1; rd_addr = 8'h90; tick();
    check_rd("t1.flo", 1'b1, 8'h00);
    rd_addr = 8'h91; tick();
    check_rd("t1.fhi", 1'b1, 8'h00);
    rd_addr = 8'h83; tick();
    check_rd("t1.port3", 1'b1, 8'hA5);
    rd_en = 1'b0; tick();
    check("t1.idle_valid", {15'd0, rd_valid}, 16'h0000);
    check("t1.idle_hit",   {15'd0, rd_hit},   16'h0000);
    check("t1.idle_hold",  {8'd0, rd_data},   16'h00A5);

    // T2: pin 5 change shows up on the third response after the change
    pin[5] = 8'h3C; rd_en = 1'b1; rd_addr = 8'h85;
    tick();
    check_rd("t2.T+1", 1'b1, 8'h00);
    tick();
    check_rd("t2.T+2", 1'b1, 8'h00);
    tick();
    check_rd("t2.T+3", 1'b1, 8'h3C);
    rd_addr = 8'h90; tick();
    check_rd("t2.flag5", 1'b1, 8'h20);

    // T3: read-to-clear, then set and clear landing together
    rd_addr = 8'h85; tick();
    check_rd("t3.rd85", 1'b1, 8'h3C);
    rd_addr = 8'h90; tick();
    check_rd("t3.cleared", 1'b1, 8'h00);
    rd_en = 1'b0; pin[5] = 8'h11;
    tick(2);
    rd_en = 1'b1; rd_addr = 8'h85; tick();
    check_rd("t3.rd_set", 1'b1, 8'h11);
    rd_addr = 8'h90; tick();
    check_rd("t3.set_wins", 1'b1, 8'h20);
    rd_addr = 8'h85; tick();
    check_rd("t3.clear5", 1'b1, 8'h11);

    // T4: address decode
    rd_addr = 8'h7F; tick();
    check_rd("t4.7F", 1'b0, 8'h00);
    rd_addr = 8'h92; tick();
    check_rd("t4.92", 1'b0, 8'h00);
    rd_addr = 8'hFF; tick();
    check_rd("t4.FF", 1'b0, 8'h00);
    rd_en = 1'b0; pin[12] = 8'h77;
    tick(3);
    rd_en = 1'b1; rd_addr = 8'h91; tick();
    check_rd("t4.flag12", 1'b1, 8'h10);
    rd_addr = 8'h8C; tick();
    check_rd("t4.port12", 1'b1, 8'h77);
    rd_en = 1'b0;

    // T5: only masked flags raise irq; stays 0 without the interrupt build
    irq_mask_wr = 1'b1; irq_mask_din = 16'h0001; tick();
    irq_mask_wr = 1'b0; irq_mask_din = 16'hFFFF;
    pin[1] = 8'h01;
    tick(5);
    check("t5.unmasked", {15'd0, irq}, 16'h0000);
    pin[0] = 8'h5A;
    tick(3);
    check("t5.flag_edge", {15'd0, irq}, 16'h0000);
    tick();
    check("t5.irq_set", {15'd0, irq}, {15'd0, IrqEn});
    rd_en = 1'b1; rd_addr = 8'h80; tick();
    check_rd("t5.rd80", 1'b1, 8'h5A);
    check("t5.irq_hold", {15'd0, irq}, {15'd0, IrqEn});
    rd_en = 1'b0; tick();
    check("t5.irq_drop", {15'd0, irq}, 16'h0000);

    // T6: reset with a read in flight; flag[1] is lost and warm-up restarts
    rd_en = 1'b1; rd_addr = 8'h85; rst = 1'b1; tick();
    check("t6.valid", {15'd0, rd_valid}, 16'h0000);
    check("t6.hit",   {15'd0, rd_hit},   16'h0000);
    check("t6.data",  {8'd0, rd_data},   16'h0000);
    check("t6.irq",   {15'd0, irq},      16'h0000);
    rst = 1'b0; rd_en = 1'b0; pin[7] = 8'hC3;
    tick(6);
    rd_en = 1'b1; rd_addr = 8'h90; tick();
    check_rd("t6.flo", 1'b1, 8'h00);
    rd_addr = 8'h91; tick();
    check_rd("t6.fhi", 1'b1, 8'h00);
    rd_en = 1'b0; pin[7] = 8'h3C;
    tick(3);
    rd_en = 1'b1; rd_addr = 8'h90; tick();
    check_rd("t6.flag7", 1'b1, 8'h80);
    rd_en = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
